// File: rtl/spram_arb_pkg.sv
// Shared types for the SPRAM arbiter: phase and grant encodings
// plus the byte-lane write masks for the 16-bit SPRAM word.
package spram_arb_pkg;

   typedef enum logic {
      ST_LOAD,
      ST_RUN
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_LD,
      GNT_RD,
      GNT_WR
   } grant_t;

   localparam logic [3:0] MASK_LO  = 4'b0011;
   localparam logic [3:0] MASK_HI  = 4'b1100;
   localparam logic [3:0] MASK_ALL = 4'b1111;

endpackage

// File: rtl/spram_arbiter.sv
// spram_arbiter: sole owner of the SP256K SPRAM port. Boot loader only in
// LOAD; in RUN reads have priority, a pending byte write wins after
// WR_MAX_WAIT refusals.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   load_done             loader finished (level)
//   ld_req/addr/data/ack  loader word writes (LOAD phase only)
//   rd_req/addr/ack       word reads; rd_valid/rd_data one cycle after ack
//   wr_req/addr/data/ack  byte writes; wr_addr[0] selects the lane
//   running               1 once in RUN phase
//   spram_*               SPRAM macro pins (DO is an input)
module spram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int unsigned WR_MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_done,
   input  logic        ld_req,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data,
   output logic        ld_ack,
   input  logic        rd_req,
   input  logic [15:0] rd_addr,
   output logic        rd_ack,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   input  logic        wr_req,
   input  logic [16:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        wr_ack,
   output logic        running,
   output logic [15:0] spram_addr,
   output logic [15:0] spram_di,
   output logic [3:0]  spram_maskwe,
   output logic        spram_we,
   output logic        spram_cs,
   input  logic [15:0] spram_do
);

   localparam logic [3:0] WMAX = 4'(WR_MAX_WAIT);

   arb_state_t  state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic        rd_valid_q;
   logic [15:0] addr_q;
   grant_t      gnt;

   // Grant decode. Held in reset so nothing touches the SPRAM
   // while reset_n is low.
   always_comb begin
      gnt = GNT_NONE;
      if (reset_n) begin
         if (state_q == ST_LOAD) begin
            if (ld_req) gnt = GNT_LD;
         end else if (rd_req && wr_req) begin
            gnt = (wait_q >= WMAX) ? GNT_WR : GNT_RD;
         end else if (rd_req) begin
            gnt = GNT_RD;
         end else if (wr_req) begin
            gnt = GNT_WR;
         end
      end
   end

   // Next state: RUN is entered once the loader is idle and done.
   // wait_d counts consecutive refusals of a pending write.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_LOAD && load_done && !ld_req)
         state_d = ST_RUN;
      wait_d = '0;
      if (gnt == GNT_RD && wr_req)
         wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_LOAD;
         wait_q     <= '0;
         rd_valid_q <= 1'b0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         rd_valid_q <= rd_ack;
         addr_q     <= spram_addr;
      end
   end

   // Output decode; an idle cycle keeps the last address on AD.
   always_comb begin
      ld_ack       = 1'b0;
      rd_ack       = 1'b0;
      wr_ack       = 1'b0;
      spram_cs     = 1'b0;
      spram_we     = 1'b0;
      spram_addr   = addr_q;
      spram_di     = '0;
      spram_maskwe = '0;
      unique case (gnt)
         GNT_LD: begin
            ld_ack       = 1'b1;
            spram_cs     = 1'b1;
            spram_we     = 1'b1;
            spram_addr   = ld_addr;
            spram_di     = ld_data;
            spram_maskwe = MASK_ALL;
         end
         GNT_RD: begin
            rd_ack     = 1'b1;
            spram_cs   = 1'b1;
            spram_addr = rd_addr;
         end
         GNT_WR: begin
            wr_ack       = 1'b1;
            spram_cs     = 1'b1;
            spram_we     = 1'b1;
            spram_addr   = wr_addr[16:1];
            spram_di     = {wr_data, wr_data};
            spram_maskwe = wr_addr[0] ? MASK_HI : MASK_LO;
         end
         default: ;
      endcase
   end

   assign running  = (state_q == ST_RUN);
   // A reset arriving while a read is in flight kills its valid.
   assign rd_valid = rd_valid_q & reset_n;
   assign rd_data  = spram_do;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: SPRAM model, directed cases
// with literal expectations, then randomized traffic against a model.
module tb_spram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n, load_done;
   logic        ld_req, ld_ack;
   logic [15:0] ld_addr, ld_data;
   logic        rd_req, rd_ack, rd_valid;
   logic [15:0] rd_addr, rd_data;
   logic        wr_req, wr_ack;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;
   logic        running;
   logic [15:0] spram_addr, spram_di;
   logic [3:0]  spram_maskwe;
   logic        spram_we, spram_cs;
   logic [15:0] spram_do = 16'h0000;

   always #25 clk = ~clk;

   spram_arbiter #(.WR_MAX_WAIT(4)) dut (
      .clk(clk), .reset_n(reset_n), .load_done(load_done),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ack(ld_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .running(running),
      .spram_addr(spram_addr), .spram_di(spram_di),
      .spram_maskwe(spram_maskwe), .spram_we(spram_we),
      .spram_cs(spram_cs), .spram_do(spram_do)
   );

   // SPRAM macro: registered read, nibble-masked write
   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] mw;

   always @(posedge clk) begin
      if (spram_cs) begin
         if (spram_we) begin
            mw = mem[spram_addr];
            for (int k = 0; k < 4; k++)
               if (spram_maskwe[k]) mw[4*k +: 4] = spram_di[4*k +: 4];
            mem[spram_addr] <= mw;
         end else begin
            spram_do <= mem[spram_addr];
         end
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: phase, consecutive write refusals, pending read
   bit          m_known = 0;
   bit          m_run, m_rdv, m_addr_known;
   int          m_refuse;
   logic [15:0] m_rdata, m_last;

   always @(negedge clk) begin
      int          eg;
      logic [15:0] ea;
      eg = 0;
      ea = m_last;
      if (reset_n) begin
         if (!m_run) eg = ld_req ? 1 : 0;
         else if (rd_req && wr_req) eg = (m_refuse >= 4) ? 3 : 2;
         else if (rd_req) eg = 2;
         else if (wr_req) eg = 3;
      end
      case (eg)
         1: ea = ld_addr;
         2: ea = rd_addr;
         3: ea = wr_addr[16:1];
         default: ;
      endcase
      if (m_known) begin
         chk("acks", 32'({ld_ack, rd_ack, wr_ack}),
             32'({eg == 1, eg == 2, eg == 3}));
         chk("cs_we", 32'({spram_cs, spram_we}),
             32'({eg != 0, eg == 1 || eg == 3}));
         chk("running", 32'(running), 32'(m_run));
         chk("rd_valid", 32'(rd_valid), 32'(m_rdv && reset_n));
         if (m_rdv && reset_n)
            chk("rd_data", 32'(rd_data), 32'(m_rdata));
         if (eg != 0 || m_addr_known)
            chk("addr", 32'(spram_addr), 32'(ea));
         if (eg == 1) begin
            chk("ld_di", 32'(spram_di), 32'(ld_data));
            chk("ld_mask", 32'(spram_maskwe), 32'hF);
         end
         if (eg == 3) begin
            chk("wr_di", 32'(spram_di), 32'({wr_data, wr_data}));
            chk("wr_mask", 32'(spram_maskwe),
                wr_addr[0] ? 32'hC : 32'h3);
         end
      end
      if (!reset_n) begin
         m_known = 1; m_run = 0; m_refuse = 0;
         m_rdv = 0; m_addr_known = 0;
      end else if (m_known) begin
         case (eg)
            1: ref_mem[ld_addr] = ld_data;
            2: m_rdata = ref_mem[rd_addr];
            3: if (wr_addr[0]) ref_mem[wr_addr[16:1]][15:8] = wr_data;
               else ref_mem[wr_addr[16:1]][7:0] = wr_data;
            default: ;
         endcase
         m_rdv = (eg == 2);
         if (eg != 0) begin m_last = ea; m_addr_known = 1; end
         if (rd_req && wr_req && eg == 2)
            m_refuse = (m_refuse < 15) ? m_refuse + 1 : 15;
         else
            m_refuse = 0;
         if (!m_run && load_done && !ld_req) m_run = 1;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      logic ra, wa;
      int   lcnt;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'h0000; ref_mem[i] = 16'h0000;
      end
      mem[16'h1234] = 16'hBEEF; ref_mem[16'h1234] = 16'hBEEF;
      reset_n = 0; load_done = 0;
      ld_req = 0; ld_addr = 0; ld_data = 0;
      rd_req = 0; rd_addr = 0;
      wr_req = 0; wr_addr = 0; wr_data = 0;
      step(); step();
      reset_n = 1;
      @(negedge clk);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_acks", 32'({ld_ack, rd_ack, wr_ack, spram_cs}), 32'd0);
      step();
      // load words 0..3, reads refused meanwhile
      for (int i = 0; i < 4; i++) begin
         ld_req = 1; ld_addr = 16'(i); ld_data = 16'h1000 + 16'(i);
         rd_req = 1; rd_addr = 16'(i);
         @(negedge clk);
         chk("ld_ack", 32'({ld_ack, spram_we, spram_maskwe}), 32'h3F);
         chk("ld_rd_ack", 32'(rd_ack), 32'd0);
         step();
      end
      rd_req = 0;
      load_done = 1; ld_addr = 16'd4; ld_data = 16'h1004;
      step();
      @(negedge clk);
      chk("ld_busy_stay", 32'({running, ld_ack}), 32'h1);
      step();
      ld_req = 0;
      step();
      @(negedge clk);
      chk("run_entered", 32'(running), 32'd1);
      step();
      ld_req = 1;
      @(negedge clk);
      chk("run_ld_ign", 32'(ld_ack), 32'd0);
      step();
      ld_req = 0;
      // single read
      rd_req = 1; rd_addr = 16'h1234;
      @(negedge clk);
      chk("rd_ack", 32'({rd_ack, spram_we}), 32'h2);
      step();
      rd_req = 0;
      @(negedge clk);
      chk("rd_valid1", 32'({rd_valid, rd_data}), 32'h1BEEF);
      step();
      @(negedge clk);
      chk("rd_valid0", 32'(rd_valid), 32'd0);
      // byte write to high lane of word 2
      wr_req = 1; wr_addr = 17'h00005; wr_data = 8'hA5;
      @(negedge clk);
      chk("wr_pins", 32'({wr_ack, spram_maskwe, spram_addr}), 32'h1C0002);
      chk("wr_di", 32'(spram_di), 32'hA5A5);
      step();
      wr_req = 0; rd_req = 1; rd_addr = 16'h0002;
      step();
      rd_req = 0;
      @(negedge clk);
      chk("wr_readback", 32'(rd_data), 32'hA502);
      step();
      // write starved by a stream of reads
      rd_req = 1; rd_addr = 16'h0007;
      wr_req = 1; wr_addr = 17'h00010; wr_data = 8'h3C;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("starve_rd", 32'({rd_ack, wr_ack}), 32'h2);
         step();
      end
      @(negedge clk);
      chk("starve_wr", 32'({rd_ack, wr_ack}), 32'h1);
      step();
      wr_req = 0;
      @(negedge clk);
      chk("reads_resume", 32'({rd_ack, wr_ack}), 32'h2);
      step();
      // reset right after a read ack
      reset_n = 0; load_done = 0;
      @(negedge clk);
      chk("rst_kill_valid", 32'({rd_valid, rd_ack}), 32'd0);
      step();
      reset_n = 1;
      @(negedge clk);
      chk("rst_state", 32'({running, rd_ack}), 32'd0);
      step(); step();
      load_done = 1;
      step();
      @(negedge clk);
      chk("rerun", 32'({running, rd_ack}), 32'h3);
      // randomized traffic
      lcnt = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         ra = rd_ack; wa = wr_ack;
         @(posedge clk); #1;
         if (!rd_req || ra || $urandom_range(15) == 0) begin
            rd_req  = ($urandom_range(3) != 0);
            rd_addr = 16'($urandom_range(63));
         end
         if (!wr_req || wa || $urandom_range(15) == 0) begin
            wr_req  = $urandom_range(1) == 1;
            wr_addr = 17'($urandom_range(127));
            wr_data = 8'($urandom);
         end
         ld_req  = $urandom_range(1) == 1;
         ld_addr = 16'($urandom_range(63));
         ld_data = 16'($urandom);
         if (lcnt > 0) lcnt--;
         else load_done = 1;
         reset_n = ($urandom_range(299) != 0);
         if (!reset_n) begin
            load_done = 0;
            lcnt = $urandom_range(20);
         end
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
